// File: rtl/lm80c_int_ctrl.sv
`default_nettype none
//============================================================================
// Module      : lm80c_int_ctrl
// Description : Z80 mode-2 interrupt daisy-chain controller for the LM80C.
//               It merges level requests from CTC, SIO, PIO and spares into
//               one CPU INT_n. It returns the winning source's vector during
//               the IORQ+M1 acknowledge, tracks in-service state per source,
//               and decodes RETI (ED 4D) on opcode fetches. That decoding
//               stands in for the IEI/IEO chain the peripheral cores lack.
// Ports       : sys_clock, reset_n (async, active low), clk_ena (CPU enable)
//               irq_req[NUM_SRC]   level requests, index 0 = highest prio
//               vec_in[8*NUM_SRC]  per-source vector bytes
//               m1_n/iorq_n/mreq_n/rd_n, bus_din   CPU bus observation
//               int_n, vec_o, vec_oe, ack_o, in_service, reti_o   outputs
// Revision    : 1.0  initial release
//============================================================================
module lm80c_int_ctrl #(
    parameter int          NUM_SRC  = 4,
    parameter logic [7:0]  RETI_OP1 = 8'hED,
    parameter logic [7:0]  RETI_OP2 = 8'h4D
) (
    input  logic                   sys_clock,
    input  logic                   reset_n,
    input  logic                   clk_ena,
    input  logic [NUM_SRC-1:0]     irq_req,
    input  logic [8*NUM_SRC-1:0]   vec_in,
    input  logic                   m1_n,
    input  logic                   iorq_n,
    input  logic                   mreq_n,
    input  logic                   rd_n,
    input  logic [7:0]             bus_din,
    output logic                   int_n,
    output logic [7:0]             vec_o,
    output logic                   vec_oe,
    output logic [NUM_SRC-1:0]     ack_o,
    output logic [NUM_SRC-1:0]     in_service,
    output logic                   reti_o
);

    localparam logic [NUM_SRC-1:0] c_one = NUM_SRC'(1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_GOT_ED = 1'b1
    } reti_state_t;

    reti_state_t          r_state;
    reti_state_t          w_state_nxt;

    logic                 r_ack_q;
    logic                 r_fetch_q;
    logic [7:0]           r_op_q;
    logic                 r_int_n;
    logic [7:0]           r_vec;
    logic [NUM_SRC-1:0]   r_ack;
    logic [NUM_SRC-1:0]   r_in_service;
    logic                 r_reti;

    logic                 w_ack_now;
    logic                 w_ack_rise;
    logic                 w_fetch_now;
    logic                 w_fetch_end;
    logic [NUM_SRC-1:0]   w_elig;
    logic [NUM_SRC-1:0]   w_win_hot;
    logic [7:0]           w_win_vec;
    logic                 w_reti_hit;

    // Bus cycle decode. An acknowledge takes precedence over a fetch that
    // appears in the same tick, so the fetch is masked out entirely.
    assign w_ack_now   = ~m1_n & ~iorq_n;
    assign w_ack_rise  = w_ack_now & ~r_ack_q;
    assign w_fetch_now = ~m1_n & ~mreq_n & ~rd_n & ~w_ack_now;
    assign w_fetch_end = r_fetch_q & rd_n & ~w_ack_rise;

    // A source is blocked by any in-service source of equal or higher
    // priority (lower or equal index); lower-priority service allows nesting.
    always_comb begin
        logic v_blk;
        v_blk  = 1'b0;
        w_elig = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            v_blk     = v_blk | r_in_service[i];
            w_elig[i] = irq_req[i] & ~v_blk;
        end
    end

    // Winner is the lowest eligible index: isolate the lowest set bit and
    // scan downwards so the lowest match is the last assignment.
    assign w_win_hot = w_elig & (-w_elig);

    always_comb begin
        w_win_vec = 8'hFF;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_win_vec = vec_in[8*i +: 8];
            end
        end
    end

    // RETI recogniser, stepped once per completed opcode fetch.
    always_comb begin
        w_state_nxt = r_state;
        w_reti_hit  = 1'b0;
        if (w_fetch_end) begin
            case (r_state)
                ST_IDLE: begin
                    if (r_op_q == RETI_OP1) begin
                        w_state_nxt = ST_GOT_ED;
                    end
                end
                ST_GOT_ED: begin
                    if (r_op_q == RETI_OP2) begin
                        w_reti_hit  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else if (r_op_q == RETI_OP1) begin
                        w_state_nxt = ST_GOT_ED;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else if (clk_ena) begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ack_q      <= 1'b0;
            r_fetch_q    <= 1'b0;
            r_op_q       <= 8'h00;
            r_int_n      <= 1'b1;
            r_vec        <= 8'hFF;
            r_ack        <= '0;
            r_in_service <= '0;
            r_reti       <= 1'b0;
        end else if (clk_ena) begin
            r_ack_q   <= w_ack_now;
            r_fetch_q <= w_fetch_now;
            if (w_fetch_now) begin
                r_op_q <= bus_din;
            end
            r_ack   <= '0;
            r_reti  <= w_reti_hit;
            r_int_n <= ~|w_elig;
            if (w_ack_rise) begin
                if (|w_elig) begin
                    r_vec        <= w_win_vec;
                    r_in_service <= r_in_service | w_win_hot;
                    r_ack        <= w_win_hot;
                    // The winner is the lowest eligible index, so nothing of
                    // higher priority can still be asking: INT_n drops away.
                    r_int_n      <= 1'b1;
                end else begin
                    // Request withdrawn before the acknowledge: the CPU still
                    // reads a byte, so hand it the idle bus value.
                    r_vec <= 8'hFF;
                end
            end else if (w_reti_hit) begin
                // RETI ends the highest-priority active service routine.
                r_in_service <= r_in_service & (r_in_service - c_one);
            end
        end
    end

    assign int_n      = r_int_n;
    assign vec_o      = r_vec;
    assign vec_oe     = r_ack_q;
    assign ack_o      = r_ack;
    assign in_service = r_in_service;
    assign reti_o     = r_reti;

endmodule
`default_nettype wire

// File: tb/tb_lm80c_int_ctrl.sv
`default_nettype none
//============================================================================
// Module      : tb_lm80c_int_ctrl
// Description : Directed bench for lm80c_int_ctrl. A cycle-level reference
//               model is compared on every falling clock edge. Literal
//               expectations at key points pin both DUT and model.
// Revision    : 1.0  initial release
//============================================================================
module tb_lm80c_int_ctrl;

    logic        sys_clock = 1'b0;
    logic        reset_n   = 1'b0;
    logic        clk_ena   = 1'b1;
    logic [3:0]  irq_req   = 4'b0000;
    logic [31:0] vec_in    = {8'h3C, 8'h24, 8'h18, 8'h10};
    logic        m1_n      = 1'b1;
    logic        iorq_n    = 1'b1;
    logic        mreq_n    = 1'b1;
    logic        rd_n      = 1'b1;
    logic [7:0]  bus_din   = 8'h00;

    wire         int_n;
    wire [7:0]   vec_o;
    wire         vec_oe;
    wire [3:0]   ack_o;
    wire [3:0]   in_service;
    wire         reti_o;

    int vectors     = 0;
    int miscompares = 0;
    int reti_cnt    = 0;

    lm80c_int_ctrl #(
        .NUM_SRC  (4),
        .RETI_OP1 (8'hED),
        .RETI_OP2 (8'h4D)
    ) u_dut (
        .sys_clock  (sys_clock),
        .reset_n    (reset_n),
        .clk_ena    (clk_ena),
        .irq_req    (irq_req),
        .vec_in     (vec_in),
        .m1_n       (m1_n),
        .iorq_n     (iorq_n),
        .mreq_n     (mreq_n),
        .rd_n       (rd_n),
        .bus_din    (bus_din),
        .int_n      (int_n),
        .vec_o      (vec_o),
        .vec_oe     (vec_oe),
        .ack_o      (ack_o),
        .in_service (in_service),
        .reti_o     (reti_o)
    );

    initial forever #5 sys_clock = ~sys_clock;

    // ---------------- reference model ----------------
    // RETI is recognised as "this fetched byte is 4D and the previously
    // fetched byte was ED", which is what the prefix tracker amounts to.
    logic       m_int_n, m_ack_q, m_reti, m_fetch_q;
    logic [7:0] m_vec, m_op, m_last;
    logic [3:0] m_ack, m_insvc;
    int         m_reti_cnt = 0;

    always @(posedge sys_clock or negedge reset_n) begin
        logic       acknow, fnow, rise, fend, nxt_int, done;
        logic [3:0] elig;
        int         win;
        if (!reset_n) begin
            m_int_n = 1'b1; m_vec = 8'hFF; m_ack_q = 1'b0; m_ack = 4'b0;
            m_insvc = 4'b0; m_reti = 1'b0; m_fetch_q = 1'b0;
            m_op = 8'h00; m_last = 8'h00;
        end else if (clk_ena) begin
            acknow = !m1_n && !iorq_n;
            fnow   = !m1_n && !mreq_n && !rd_n && !acknow;
            rise   = acknow && !m_ack_q;
            fend   = m_fetch_q && rd_n && !rise;
            elig   = 4'b0;
            for (int i = 0; i < 4; i++)
                elig[i] = irq_req[i] && ((int'(m_insvc) & ((2 << i) - 1)) == 0);
            m_ack   = 4'b0;
            m_reti  = 1'b0;
            nxt_int = (elig == 4'b0);
            if (rise) begin
                if (elig != 4'b0) begin
                    win = 0;
                    for (int i = 3; i >= 0; i--) if (elig[i]) win = i;
                    m_vec        = vec_in[8*win +: 8];
                    m_insvc[win] = 1'b1;
                    m_ack[win]   = 1'b1;
                    nxt_int      = 1'b1;
                end else begin
                    m_vec = 8'hFF;
                end
            end
            if (fend) begin
                if (m_last == 8'hED && m_op == 8'h4D) begin
                    m_reti = 1'b1;
                    m_reti_cnt++;
                    done = 1'b0;
                    for (int i = 0; i < 4; i++) begin
                        if (!done && m_insvc[i]) begin
                            m_insvc[i] = 1'b0;
                            done = 1'b1;
                        end
                    end
                end
                m_last = m_op;
            end
            if (fnow) m_op = bus_din;
            m_int_n   = nxt_int;
            m_ack_q   = acknow;
            m_fetch_q = fnow;
        end
    end

    // ---------------- helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge sys_clock);
        #1;
    endtask

    task automatic lit(input string name, input logic [31:0] dut,
                       input logic [31:0] mdl, input logic [31:0] exp);
        vectors++;
        if (dut !== exp || mdl !== exp) begin
            miscompares++;
            $display("FAIL %s: dut=%h model=%h expected=%h", name, dut, mdl, exp);
        end
    endtask

    task automatic ack_begin();
        m1_n = 1'b0; iorq_n = 1'b0;
        tick(1);
    endtask

    task automatic ack_end();
        tick(1);
        m1_n = 1'b1; iorq_n = 1'b1;
        tick(2);
    endtask

    task automatic fetch(input logic [7:0] b);
        m1_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0; bus_din = b;
        tick(2);
        m1_n = 1'b1; mreq_n = 1'b1; rd_n = 1'b1;
        tick(2);
    endtask

    task automatic reti_seq();
        fetch(8'hED);
        fetch(8'h4D);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus and checking ----------------
    initial begin
        fork
            begin
                @(posedge sys_clock);
                forever begin
                    @(negedge sys_clock);
                    vectors++;
                    if (reti_o === 1'b1) reti_cnt++;
                    if (int_n !== m_int_n || vec_o !== m_vec || vec_oe !== m_ack_q ||
                        ack_o !== m_ack || in_service !== m_insvc || reti_o !== m_reti) begin
                        miscompares++;
                        $display("FAIL cycle@%0t dut/model: int_n %b/%b vec_o %h/%h vec_oe %b/%b ack_o %b/%b in_service %b/%b reti_o %b/%b",
                                 $time, int_n, m_int_n, vec_o, m_vec, vec_oe, m_ack_q,
                                 ack_o, m_ack, in_service, m_insvc, reti_o, m_reti);
                    end
                end
            end
        join_none

        // Reset state with every request active.
        irq_req = 4'b1111;
        tick(3);
        lit("rst int_n", 32'(int_n), 32'(m_int_n), 32'h1);
        lit("rst in_service", 32'(in_service), 32'(m_insvc), 32'h0);
        lit("rst vec_o", 32'(vec_o), 32'(m_vec), 32'hFF);
        lit("rst vec_oe", 32'(vec_oe), 32'(m_ack_q), 32'h0);
        reset_n = 1'b1;
        tick(1);
        lit("post-rst int_n", 32'(int_n), 32'(m_int_n), 32'h0);
        irq_req = 4'b0000;
        tick(2);

        // Single source.
        irq_req = 4'b0100;
        tick(2);
        lit("single int_n low", 32'(int_n), 32'(m_int_n), 32'h0);
        ack_begin();
        lit("single vec_oe", 32'(vec_oe), 32'(m_ack_q), 32'h1);
        lit("single vec_o", 32'(vec_o), 32'(m_vec), 32'h24);
        lit("single ack_o", 32'(ack_o), 32'(m_ack), 32'h4);
        lit("single in_service", 32'(in_service), 32'(m_insvc), 32'h4);
        lit("single int_n high", 32'(int_n), 32'(m_int_n), 32'h1);
        tick(1);
        lit("single ack_o ends", 32'(ack_o), 32'(m_ack), 32'h0);
        lit("single vec_o held", 32'(vec_o), 32'(m_vec), 32'h24);
        m1_n = 1'b1; iorq_n = 1'b1;
        tick(2);
        irq_req = 4'b0000;
        reti_seq();
        lit("single reti clr", 32'(in_service), 32'(m_insvc), 32'h0);
        lit("reti count 1", 32'(reti_cnt), 32'(m_reti_cnt), 32'd1);

        // Priority: 1 beats 3, 3 blocked until RETI.
        irq_req = 4'b1010;
        tick(2);
        ack_begin();
        lit("prio vec_o", 32'(vec_o), 32'(m_vec), 32'h18);
        lit("prio ack_o", 32'(ack_o), 32'(m_ack), 32'h2);
        lit("prio in_service", 32'(in_service), 32'(m_insvc), 32'h2);
        ack_end();
        irq_req = 4'b1000;
        tick(2);
        lit("prio src3 blocked", 32'(int_n), 32'(m_int_n), 32'h1);
        reti_seq();
        lit("prio reti in_service", 32'(in_service), 32'(m_insvc), 32'h0);
        lit("prio int_n after reti", 32'(int_n), 32'(m_int_n), 32'h0);
        lit("reti count 2", 32'(reti_cnt), 32'(m_reti_cnt), 32'd2);
        ack_begin();
        lit("prio vec_o src3", 32'(vec_o), 32'(m_vec), 32'h3C);
        lit("prio in_service src3", 32'(in_service), 32'(m_insvc), 32'h8);
        ack_end();
        irq_req = 4'b0000;
        reti_seq();

        // Nesting.
        irq_req = 4'b0100;
        tick(2);
        ack_begin();
        ack_end();
        irq_req = 4'b0101;
        tick(2);
        lit("nest int_n", 32'(int_n), 32'(m_int_n), 32'h0);
        ack_begin();
        lit("nest vec_o", 32'(vec_o), 32'(m_vec), 32'h10);
        lit("nest ack_o", 32'(ack_o), 32'(m_ack), 32'h1);
        lit("nest in_service", 32'(in_service), 32'(m_insvc), 32'h5);
        ack_end();
        irq_req = 4'b0000;
        reti_seq();
        lit("nest reti1", 32'(in_service), 32'(m_insvc), 32'h4);
        reti_seq();
        lit("nest reti2", 32'(in_service), 32'(m_insvc), 32'h0);
        lit("reti count 5", 32'(reti_cnt), 32'(m_reti_cnt), 32'd5);

        // RETI decoding variants with sources 0 and 1 in service.
        irq_req = 4'b0010;
        tick(2);
        ack_begin();
        ack_end();
        irq_req = 4'b0011;
        tick(2);
        ack_begin();
        lit("dec in_service", 32'(in_service), 32'(m_insvc), 32'h3);
        ack_end();
        irq_req = 4'b0000;
        fetch(8'hED); fetch(8'hED); fetch(8'h4D);
        lit("dec ED ED 4D", 32'(in_service), 32'(m_insvc), 32'h2);
        fetch(8'hED); fetch(8'h45);
        lit("dec RETN", 32'(in_service), 32'(m_insvc), 32'h2);
        fetch(8'hED); fetch(8'h00); fetch(8'h4D);
        lit("dec ED 00 4D", 32'(in_service), 32'(m_insvc), 32'h2);
        fetch(8'h4D);
        lit("dec 4D alone", 32'(in_service), 32'(m_insvc), 32'h2);
        lit("reti count 6", 32'(reti_cnt), 32'(m_reti_cnt), 32'd6);
        reti_seq();
        lit("dec final clr", 32'(in_service), 32'(m_insvc), 32'h0);
        reti_seq();
        lit("reti idle count 8", 32'(reti_cnt), 32'(m_reti_cnt), 32'd8);
        lit("reti idle in_service", 32'(in_service), 32'(m_insvc), 32'h0);

        // Withdrawn request.
        irq_req = 4'b0001;
        tick(2);
        lit("wd int_n", 32'(int_n), 32'(m_int_n), 32'h0);
        irq_req = 4'b0000;
        ack_begin();
        lit("wd vec_o", 32'(vec_o), 32'(m_vec), 32'hFF);
        lit("wd ack_o", 32'(ack_o), 32'(m_ack), 32'h0);
        lit("wd in_service", 32'(in_service), 32'(m_insvc), 32'h0);
        lit("wd vec_oe", 32'(vec_oe), 32'(m_ack_q), 32'h1);
        ack_end();

        // Clock-enable freeze with an ack pulse in flight.
        irq_req = 4'b0100;
        tick(2);
        ack_begin();
        clk_ena = 1'b0;
        irq_req = 4'b0001;
        tick(3);
        lit("frz ack_o", 32'(ack_o), 32'(m_ack), 32'h4);
        lit("frz vec_o", 32'(vec_o), 32'(m_vec), 32'h24);
        lit("frz int_n", 32'(int_n), 32'(m_int_n), 32'h1);
        lit("frz in_service", 32'(in_service), 32'(m_insvc), 32'h4);
        clk_ena = 1'b1;
        tick(1);
        lit("frz ack_o ends", 32'(ack_o), 32'(m_ack), 32'h0);
        lit("frz nested int_n", 32'(int_n), 32'(m_int_n), 32'h0);
        m1_n = 1'b1; iorq_n = 1'b1;
        irq_req = 4'b0000;
        tick(2);
        reti_seq();
        lit("frz reti", 32'(in_service), 32'(m_insvc), 32'h0);
        lit("reti count 9", 32'(reti_cnt), 32'(m_reti_cnt), 32'd9);

        // Reset in the middle of an acknowledge.
        irq_req = 4'b0010;
        tick(2);
        ack_begin();
        reset_n = 1'b0;
        #1;
        lit("mid-rst int_n", 32'(int_n), 32'(m_int_n), 32'h1);
        lit("mid-rst in_service", 32'(in_service), 32'(m_insvc), 32'h0);
        lit("mid-rst vec_oe", 32'(vec_oe), 32'(m_ack_q), 32'h0);
        lit("mid-rst vec_o", 32'(vec_o), 32'(m_vec), 32'hFF);
        m1_n = 1'b1; iorq_n = 1'b1;
        tick(2);
        reset_n = 1'b1;
        tick(1);
        lit("mid-rst recompute", 32'(int_n), 32'(m_int_n), 32'h0);
        irq_req = 4'b0000;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
